// File: rtl/psum_accum_buf_if.sv
// psum_accum_buf_if: bundles the accumulate stream, the mode commands and the
// drained output stream of the column-top partial-sum buffer.
//   acc_*       : psum beat in (valid/ready, signed data, RAM address)
//   start_*/len/shift : mode commands, sampled on start
//   done        : buffer is idle
//   out_*       : requantized drain stream (valid/ready, data, source address)
// master = producer/controller side, slave = the buffer itself.
interface psum_accum_buf_if #(
   parameter int ADDR_PSUM = 12,
   parameter int PSUM_BW   = 32,
   parameter int OUT_BW    = 8
);
   logic                 acc_valid;
   logic                 acc_ready;
   logic [PSUM_BW-1:0]   acc_data;
   logic [ADDR_PSUM-1:0] acc_addr;
   logic                 start_clear;
   logic                 start_drain;
   logic [ADDR_PSUM:0]   len;
   logic [4:0]           shift;
   logic                 done;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_BW-1:0]    out_data;
   logic [ADDR_PSUM-1:0] out_addr;

   modport master (
      output acc_valid, acc_data, acc_addr, start_clear, start_drain, len, shift, out_ready,
      input  acc_ready, done, out_valid, out_data, out_addr
   );

   modport slave (
      input  acc_valid, acc_data, acc_addr, start_clear, start_drain, len, shift, out_ready,
      output acc_ready, done, out_valid, out_data, out_addr
   );
endinterface

// File: rtl/psum_accum_buf.sv
// psum_accum_buf: partial-sum accumulator at the top of a PE column.
// Accumulates signed psum beats into a RAM (read-modify-write, 1 beat/cycle
// with forwarding), bulk-clears a region, and drains a region as saturated,
// rounded, right-shifted OUT_BW values while zeroing each entry it reads.
// Ports: clk, resetn (async, active-low), bus (psum_accum_buf_if.slave).
module psum_accum_buf #(
   parameter int ADDR_PSUM = 12,
   parameter int PSUM_BW   = 32,
   parameter int OUT_BW    = 8
)(
   input logic             clk,
   input logic             resetn,
   psum_accum_buf_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_PSUM;
   localparam int EXT_W = PSUM_BW + 1;
   localparam logic signed [EXT_W-1:0] QMAX = EXT_W'((1 << (OUT_BW - 1)) - 1);
   localparam logic signed [EXT_W-1:0] QMIN = ~QMAX;

   typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;
   typedef struct packed {
      logic [ADDR_PSUM-1:0] addr;
      logic [PSUM_BW-1:0]   data;
   } beat_t;

   state_t               state_q, state_d;
   logic                 run_q;
   logic [ADDR_PSUM:0]   len_q, cnt_q;
   logic [4:0]           shift_q;
   logic                 accept, clr_wr, issue, pop;

   // accumulate pipeline: vld_pipe[0] = s1 stage, vld_pipe[1] = write-back stage
   logic [1:0]           vld_pipe;
   beat_t                s1_q, wb_q;
   logic [PSUM_BW-1:0]   base, sum;

   logic [PSUM_BW-1:0]   mem [DEPTH];
   logic [PSUM_BW-1:0]   rd_data;
   logic [ADDR_PSUM-1:0] rd_addr, wr_addr;
   logic [PSUM_BW-1:0]   wr_data;
   logic                 wr_en;

   // drain read in flight, requantizer and output FIFO
   logic                 dr_vld;
   logic [ADDR_PSUM-1:0] dr_addr;
   logic signed [EXT_W-1:0] ext, rnd, shd;
   logic [OUT_BW-1:0]    q;
   logic [OUT_BW-1:0]    fifo_data [2];
   logic [ADDR_PSUM-1:0] fifo_addr [2];
   logic                 wptr, rptr;
   logic [1:0]           fifo_cnt, occ_after;
   logic                 room;

   // run_q keeps acc_ready low while reset is held
   assign bus.acc_ready = run_q && (state_q == IDLE) && !bus.start_clear && !bus.start_drain;
   assign bus.done      = (state_q == IDLE);
   assign bus.out_valid = (fifo_cnt != 2'd0);
   assign bus.out_data  = fifo_data[rptr];
   assign bus.out_addr  = fifo_addr[rptr];

   assign accept = bus.acc_valid && bus.acc_ready;
   assign pop    = bus.out_valid && bus.out_ready;

   // a beat one cycle behind to the same entry has not landed in the RAM read
   assign base = (vld_pipe[1] && (wb_q.addr == s1_q.addr)) ? wb_q.data : rd_data;
   assign sum  = base + s1_q.data;

   // room is judged after this cycle's pop so a steady drain runs 1/cycle
   assign occ_after = fifo_cnt - {1'b0, pop};
   assign room      = (occ_after == 2'd0) || ((occ_after == 2'd1) && !dr_vld);

   always_comb begin
      state_d = state_q;
      clr_wr  = 1'b0;
      issue   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start_clear)      state_d = CLEAR;
            else if (bus.start_drain) state_d = DRAIN;
         end
         CLEAR: begin
            clr_wr = (cnt_q < len_q);
            if ((cnt_q + {{ADDR_PSUM{1'b0}}, 1'b1}) >= len_q) state_d = IDLE;
         end
         DRAIN: begin
            issue = (cnt_q < len_q) && room;
            if ((cnt_q == len_q) && !dr_vld && (occ_after == 2'd0)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // accumulate write-back owns the write port; mode traffic never overlaps it
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (vld_pipe[0]) begin
         wr_en   = 1'b1;
         wr_addr = s1_q.addr;
         wr_data = sum;
      end else if (clr_wr || issue) begin
         wr_en   = 1'b1;
         wr_addr = cnt_q[ADDR_PSUM-1:0];
      end
   end

   assign rd_addr = accept ? bus.acc_addr : cnt_q[ADDR_PSUM-1:0];

   // read-first: a same-edge write is not visible in rd_data
   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // round-half-up arithmetic shift in one extra bit, then saturate
   assign ext = {rd_data[PSUM_BW-1], rd_data};
   assign rnd = (shift_q == 5'd0) ? '0 : (EXT_W'(1) << (shift_q - 5'd1));
   assign shd = (ext + rnd) >>> shift_q;
   assign q   = (shd > QMAX) ? QMAX[OUT_BW-1:0] :
                (shd < QMIN) ? QMIN[OUT_BW-1:0] : shd[OUT_BW-1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         run_q    <= 1'b0;
         len_q    <= '0;
         cnt_q    <= '0;
         shift_q  <= '0;
         vld_pipe <= '0;
         s1_q     <= '0;
         wb_q     <= '0;
         dr_vld   <= 1'b0;
         dr_addr  <= '0;
         wptr     <= 1'b0;
         rptr     <= 1'b0;
         fifo_cnt <= '0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_addr[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         run_q    <= 1'b1;
         vld_pipe <= {vld_pipe[0], accept};
         s1_q     <= '{addr: bus.acc_addr, data: bus.acc_data};
         wb_q     <= '{addr: s1_q.addr, data: sum};
         if (state_q == IDLE) begin
            cnt_q <= '0;
            if (bus.start_clear || bus.start_drain) len_q <= bus.len;
            if (!bus.start_clear && bus.start_drain) shift_q <= bus.shift;
         end else if (clr_wr || issue) begin
            cnt_q <= cnt_q + {{ADDR_PSUM{1'b0}}, 1'b1};
         end
         dr_vld  <= issue;
         dr_addr <= cnt_q[ADDR_PSUM-1:0];
         if (dr_vld) begin
            fifo_data[wptr] <= q;
            fifo_addr[wptr] <= dr_addr;
            wptr            <= ~wptr;
         end
         if (pop) rptr <= ~rptr;
         fifo_cnt <= occ_after + {1'b0, dr_vld};
      end
   end
endmodule

// File: tb/tb_psum_accum_buf.sv
module tb_psum_accum_buf;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int   ref_mem [4096];
   bit   ref_unk [4096];

   psum_accum_buf_if bus ();
   psum_accum_buf dut (.clk(clk), .resetn(resetn), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint rq(int v, int sh);
      longint r;
      if (sh == 0) r = v;
      else r = (longint'(v) + (longint'(1) << (sh - 1))) >>> sh;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic beat(int a, int d);
      bus.acc_valid = 1'b1;
      bus.acc_addr  = 12'(a);
      bus.acc_data  = 32'(d);
      check("acc_ready", bus.acc_ready, 1);
      tick();
      bus.acc_valid = 1'b0;
      ref_mem[a] = ref_mem[a] + d;
   endtask

   task automatic do_clear(int n);
      int waited = 0;
      bus.start_clear = 1'b1;
      bus.len = 13'(n);
      tick();
      bus.start_clear = 1'b0;
      check("clear_busy", bus.done, 0);
      while (!bus.done && waited < n + 20) begin
         tick();
         waited++;
      end
      check("clear_cycles", waited, (n == 0) ? 1 : n);
      for (int i = 0; i < n; i++) begin
         ref_mem[i] = 0;
         ref_unk[i] = 1'b0;
      end
   endtask

   // stop_after > 0 returns mid-drain right after that many pops
   task automatic do_drain(int n, int sh, bit rnd, int stop_after);
      int got = 0, cyc = 0, first = -1, last = -1;
      bit stalled = 1'b0;
      logic [7:0]  hold_d = '0;
      logic [11:0] hold_a = '0;
      longint expd[$];
      for (int i = 0; i < n; i++) expd.push_back(rq(ref_mem[i], sh));
      bus.start_drain = 1'b1;
      bus.len   = 13'(n);
      bus.shift = 5'(sh);
      tick();
      bus.start_drain = 1'b0;
      check("drain_busy", bus.done, 0);
      while (cyc < 400) begin
         bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (stalled) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, hold_d);
            check("stall_addr", bus.out_addr, hold_a);
         end
         if (bus.out_valid && bus.out_ready) begin
            check("out_addr", bus.out_addr, got);
            if (!ref_unk[got]) check("out_data", $signed(bus.out_data), expd[got]);
            got++;
            if (first < 0) first = cyc;
            last = cyc;
            stalled = 1'b0;
            tick();
            cyc++;
            check("done_after_pop", bus.done, (got == n) ? 1 : 0);
            if (got == n || got == stop_after) break;
         end else begin
            stalled = bus.out_valid;
            hold_d  = bus.out_data;
            hold_a  = bus.out_addr;
            tick();
            cyc++;
         end
      end
      if (stop_after == 0) begin
         check("drain_beats", got, n);
         if (!rnd) check("drain_rate", last - first, n - 1);
         for (int i = 0; i < n; i++) begin
            ref_mem[i] = 0;
            ref_unk[i] = 1'b0;
         end
      end else begin
         // reads run at most two ahead of the pops and zero what they touch
         for (int i = 0; i < got; i++) ref_mem[i] = 0;
         for (int i = got; i < got + 3 && i < n; i++) ref_unk[i] = 1'b1;
      end
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int vals[6] = '{1000, 1100, -1100, 12, -12, 0};
      bus.acc_valid = 1'b0; bus.acc_data = '0; bus.acc_addr = '0;
      bus.start_clear = 1'b0; bus.start_drain = 1'b0;
      bus.len = '0; bus.shift = '0; bus.out_ready = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         ref_mem[i] = 0;
         ref_unk[i] = 1'b1;
      end

      // reset state
      tick(); tick();
      check("rst_acc_ready", bus.acc_ready, 0);
      check("rst_done", bus.done, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_addr", bus.out_addr, 0);
      resetn = 1'b1;
      tick(); tick();

      do_clear(0);
      do_clear(16);

      // forwarding on back-to-back beats to one entry
      beat(3, 5); beat(3, 7); beat(3, -2);
      check("model_addr3", ref_mem[3], 10);
      do_drain(8, 0, 1'b0, 0);

      // gap beat plus interleaved addr5/addr6
      beat(5, 4); tick(); beat(5, 6);
      for (int i = 0; i < 6; i++) beat((i % 2 == 0) ? 5 : 6, 1);
      check("model_addr5", ref_mem[5], 13);
      do_drain(8, 0, 1'b0, 0);

      // requantization with rounding and saturation
      for (int i = 0; i < 6; i++) beat(i, vals[i]);
      do_drain(6, 3, 1'b0, 0);

      // wrap-around and extreme shift
      beat(0, 32'h7FFFFFFF); beat(0, 1);
      check("model_wrap", ref_mem[0], 32'sh80000000);
      do_drain(1, 24, 1'b0, 0);

      // randomized beats, random backpressure
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) tick();
         else beat($urandom_range(0, 7), int'($urandom_range(0, 1000)) - 500);
      end
      do_drain(8, $urandom_range(0, 4), 1'b1, 0);
      do_drain(8, 0, 1'b1, 0);

      // reset in the middle of a drain
      for (int i = 0; i < 8; i++) beat(i, (i + 1) * 10);
      do_drain(8, 0, 1'b0, 3);
      resetn = 1'b0;
      #1;
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_done", bus.done, 1);
      #3 resetn = 1'b1;
      tick(); tick();
      do_drain(8, 0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
